// File: rtl/kyber_ntt_engine.sv
// Forward Cooley-Tukey / inverse Gentleman-Sande NTT over one locally buffered Kyber polynomial.
// Define NTT_INV_SCALE_EN to add the final n^-1 scaling pass in inverse mode.
module kyber_ntt_engine #(
  parameter int KYBER_N = 256,
  parameter int KYBER_Q = 3329,
  parameter int COEF_W  = 16,
  parameter int N_INV   = 3303
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mode,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(KYBER_N)-1:0] coef_raddr,
  input  logic [COEF_W-1:0]          coef_rdata,
  output logic                       coef_wen,
  output logic [$clog2(KYBER_N)-1:0] coef_waddr,
  output logic [COEF_W-1:0]          coef_wdata,
  output logic [6:0]                 zeta_addr,
  input  logic [11:0]                zeta_data
);
  localparam int AW = $clog2(KYBER_N);
  localparam logic [12:0]   Q         = 13'(KYBER_Q);
  localparam logic [12:0]   BARRETT_M = 13'((1 << 24) / KYBER_Q);
  localparam logic [AW-1:0] HALF_N    = AW'(KYBER_N / 2);
  localparam logic [AW:0]   CNT_N     = (AW+1)'(KYBER_N);
  localparam logic [AW:0]   CNT_LAST  = (AW+1)'(KYBER_N - 1);

  typedef enum logic [2:0] {IDLE, LOAD, GROUP, BF_A, BF_B, SCALE, STORE, DONE} state_t;

  // Quotient estimate is at most one short, so a single subtract lands in [0, q).
  function automatic logic [11:0] barrett(input logic [23:0] x);
    logic [36:0] prod;
    logic [12:0] qhat;
    logic [23:0] r;
    prod = {13'd0, x} * 37'(BARRETT_M);
    qhat = 13'(prod >> 24);
    r    = x - 24'(qhat) * 24'(Q);
    if (r >= 24'(Q)) r = r - 24'(Q);
    return 12'(r);
  endfunction

  function automatic logic [11:0] add_mod(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= Q) s = s - Q;
    return 12'(s);
  endfunction

  function automatic logic [11:0] sub_mod(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + Q;
    return 12'(d);
  endfunction

  state_t        state, state_nxt;
  logic          mode_r;
  logic [AW:0]   cnt;
  logic [6:0]    k;
  logic [AW-1:0] len_r, base_r, off_r;
  logic [11:0]   prod_r;
  logic [11:0]   coef_buf [KYBER_N];

  logic [AW-1:0] j_idx, p_idx, cnt_idx;
  logic [AW:0]   base_next;
  logic [11:0]   a_j, a_p, mul_in, load_val;
  logic          grp_last, layer_last, compute_last;

  assign j_idx        = base_r + off_r;
  assign p_idx        = j_idx + len_r;
  assign cnt_idx      = AW'(cnt);
  assign a_j          = coef_buf[j_idx];
  assign a_p          = coef_buf[p_idx];
  assign mul_in       = mode_r ? sub_mod(a_p, a_j) : a_p;
  assign grp_last     = (off_r == len_r - 1'b1);
  assign base_next    = {1'b0, base_r} + {len_r, 1'b0};
  assign layer_last   = (base_next == CNT_N);
  assign compute_last = grp_last && layer_last && (mode_r ? (len_r == HALF_N) : (len_r == AW'(2)));
  assign load_val     = 12'((coef_rdata >= COEF_W'(KYBER_Q)) ? coef_rdata - COEF_W'(KYBER_Q) : coef_rdata);
  assign zeta_addr    = k;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    done       = 1'b0;
    coef_wen   = 1'b0;
    coef_waddr = '0;
    coef_wdata = '0;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD:  if (cnt == CNT_N) state_nxt = GROUP;
      GROUP: state_nxt = BF_A;
      BF_A:  state_nxt = BF_B;
      BF_B: begin
        if (!grp_last) begin
          state_nxt = BF_A;
        end else if (!compute_last) begin
          state_nxt = GROUP;
        end else begin
          state_nxt = STORE;
`ifdef NTT_INV_SCALE_EN
          if (mode_r) state_nxt = SCALE;
`endif
        end
      end
`ifdef NTT_INV_SCALE_EN
      SCALE: if (cnt == CNT_LAST) state_nxt = STORE;
`endif
      STORE: begin
        coef_wen   = !reset;
        coef_waddr = cnt_idx;
        coef_wdata = COEF_W'(coef_buf[cnt_idx]);
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Loop control: k walks the twiddle table once per group, len steps once per layer.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r     <= 1'b0;
      cnt        <= '0;
      coef_raddr <= '0;
      k          <= '0;
      len_r      <= '0;
      base_r     <= '0;
      off_r      <= '0;
      prod_r     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_r <= mode;
          cnt    <= '0;
          k      <= mode ? 7'd127 : 7'd1;
          len_r  <= mode ? AW'(2) : HALF_N;
          base_r <= '0;
          off_r  <= '0;
        end
        LOAD: begin
          if (cnt < CNT_N) coef_raddr <= coef_raddr + 1'b1;
          cnt <= (cnt == CNT_N) ? '0 : cnt + 1'b1;
        end
        BF_A: prod_r <= barrett({12'd0, mul_in} * {12'd0, zeta_data});
        BF_B: begin
          if (grp_last) begin
            off_r <= '0;
            k     <= mode_r ? k - 1'b1 : k + 1'b1;
            if (layer_last) begin
              base_r <= '0;
              len_r  <= mode_r ? len_r << 1 : len_r >> 1;
            end else begin
              base_r <= AW'(base_next);
            end
          end else begin
            off_r <= off_r + 1'b1;
          end
        end
        SCALE, STORE: cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      LOAD: if (cnt != '0) coef_buf[AW'(cnt - 1'b1)] <= load_val;
      BF_B: begin
        if (mode_r) begin
          coef_buf[j_idx] <= add_mod(a_j, a_p);
          coef_buf[p_idx] <= prod_r;
        end else begin
          coef_buf[j_idx] <= add_mod(a_j, prod_r);
          coef_buf[p_idx] <= sub_mod(a_j, prod_r);
        end
      end
`ifdef NTT_INV_SCALE_EN
      SCALE: coef_buf[cnt_idx] <= barrett({12'd0, coef_buf[cnt_idx]} * {12'd0, 12'(N_INV)});
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_kyber_ntt_engine.sv
// Scoreboard bench for kyber_ntt_engine: RAM and twiddle ROM models, spec-level NTT reference.
module tb_kyber_ntt_engine;
  localparam int N = 256;
  localparam int Q = 3329;
`ifdef NTT_INV_SCALE_EN
  localparam int INV_LAT   = 2689;
  localparam int INV_SCALE = 1;
`else
  localparam int INV_LAT   = 2433;
  localparam int INV_SCALE = 128;
`endif
  localparam int FWD_LAT = 2433;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        busy, done, coef_wen;
  logic [7:0]  coef_raddr, coef_waddr;
  logic [15:0] coef_rdata = '0;
  logic [15:0] coef_wdata;
  logic [6:0]  zeta_addr;
  logic [11:0] zeta_data = '0;

  logic [15:0] ram [N];
  logic [11:0] zrom [128];
  logic        tbWe = 1'b0;
  logic [7:0]  tbWa = '0;
  logic [15:0] tbWd = '0;

  logic [15:0] expQ[$];
  int checkCount = 0;
  int failCount  = 0;
  int writeCount = 0;
  int loadData [N];
  int modelA [N];

  kyber_ntt_engine dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(busy), .done(done),
    .coef_raddr(coef_raddr), .coef_rdata(coef_rdata),
    .coef_wen(coef_wen), .coef_waddr(coef_waddr), .coef_wdata(coef_wdata),
    .zeta_addr(zeta_addr), .zeta_data(zeta_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    coef_rdata <= ram[coef_raddr];
    zeta_data  <= zrom[zeta_addr];
    if (coef_wen) ram[coef_waddr] <= coef_wdata;
    else if (tbWe) ram[tbWa] <= tbWd;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  always @(negedge clk) begin
    if (coef_wen === 1'b1) begin
      checkOutput("waddr", {24'd0, coef_waddr}, writeCount % N);
      checkOutput("wdata_range", {31'd0, coef_wdata < 16'd3329}, 1);
      checkOutput("sb_has_entry", {31'd0, expQ.size() != 0}, 1);
      if (expQ.size() != 0) checkOutput("wdata", {16'd0, coef_wdata}, {16'd0, expQ.pop_front()});
      writeCount++;
    end
  end

  function automatic int bitrev7(input int x);
    int r = 0;
    for (int b = 0; b < 7; b++) if (x & (1 << b)) r |= 1 << (6 - b);
    return r;
  endfunction

  function automatic int powZeta(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * 17) % Q;
    return r;
  endfunction

  task automatic modelForward();
    int k, z, t;
    k = 1;
    for (int len = 128; len >= 2; len = len >> 1)
      for (int s = 0; s < N; s = s + 2 * len) begin
        z = int'(zrom[k]);
        k++;
        for (int j = s; j < s + len; j++) begin
          t = (z * modelA[j + len]) % Q;
          modelA[j + len] = (modelA[j] - t + Q) % Q;
          modelA[j] = (modelA[j] + t) % Q;
        end
      end
  endtask

  task automatic loadRam();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      tbWe = 1'b1;
      tbWa = 8'(i);
      tbWd = 16'(loadData[i]);
    end
    @(negedge clk);
    tbWe = 1'b0;
  endtask

  task automatic pushModel();
    for (int i = 0; i < N; i++) expQ.push_back(16'(modelA[i]));
  endtask

  // scenario 0: plain run, 1: start/mode glitches while busy, 2: reset at cycle 1000
  task automatic applyStimulus(input logic m, input int expLat, input int scenario);
    int lat, writesBefore;
    bit busyLow;
    busyLow = 0;
    writesBefore = writeCount;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 4000) begin
      if (busy !== 1'b1) busyLow = 1;
      start = (scenario == 1 && (lat == 10 || lat == 500));
      if (start) mode = ~mode;
      if (scenario == 2 && lat == 1000) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("busy_after_reset", {31'd0, busy}, 0);
        checkOutput("done_after_reset", {31'd0, done}, 0);
        checkOutput("zeta_after_reset", {25'd0, zeta_addr}, 0);
        repeat (300) @(negedge clk);
        checkOutput("writes_after_reset", writeCount - writesBefore, 0);
        checkOutput("idle_after_reset", {31'd0, busy}, 0);
        return;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checkOutput("latency", lat, expLat);
    checkOutput("busy_held", {31'd0, busyLow}, 0);
    @(negedge clk);
    checkOutput("done_single_pulse", {31'd0, done}, 0);
    checkOutput("write_count", writeCount - writesBefore, N);
    checkOutput("sb_drained", expQ.size(), 0);
    expQ.delete();
  endtask

  initial begin
    int roundIn [N];
    for (int i = 0; i < 128; i++) zrom[i] = 12'(powZeta(bitrev7(i)));
    for (int i = 0; i < N; i++) ram[i] = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_done", {31'd0, done}, 0);
    checkOutput("rst_wen", {31'd0, coef_wen}, 0);
    checkOutput("rst_raddr", {24'd0, coef_raddr}, 0);
    checkOutput("rst_waddr", {24'd0, coef_waddr}, 0);
    checkOutput("rst_wdata", {16'd0, coef_wdata}, 0);
    checkOutput("rst_zeta", {25'd0, zeta_addr}, 0);
    reset = 1'b0;

    $display("[TB] forward of unit impulse");
    for (int i = 0; i < N; i++) loadData[i] = (i == 0) ? 1 : 0;
    loadRam();
    for (int i = 0; i < N; i++) expQ.push_back((i % 2 == 0) ? 16'd1 : 16'd0);
    applyStimulus(1'b0, FWD_LAT, 0);

    $display("[TB] inverse of impulse spectrum");
    for (int i = 0; i < N; i++) expQ.push_back((i == 0) ? 16'(INV_SCALE) : 16'd0);
    applyStimulus(1'b1, INV_LAT, 0);

    $display("[TB] random round trip");
    for (int i = 0; i < N; i++) begin
      roundIn[i]  = int'($urandom_range(Q - 1));
      loadData[i] = roundIn[i];
      modelA[i]   = roundIn[i];
    end
    loadRam();
    modelForward();
    pushModel();
    applyStimulus(1'b0, FWD_LAT, 0);
    for (int i = 0; i < N; i++) expQ.push_back(16'((roundIn[i] * INV_SCALE) % Q));
    applyStimulus(1'b1, INV_LAT, 0);

    $display("[TB] all-zero input, both modes");
    for (int i = 0; i < N; i++) loadData[i] = 0;
    loadRam();
    for (int i = 0; i < N; i++) expQ.push_back(16'd0);
    applyStimulus(1'b0, FWD_LAT, 0);
    for (int i = 0; i < N; i++) expQ.push_back(16'd0);
    applyStimulus(1'b1, INV_LAT, 0);

    $display("[TB] start and mode glitches while busy, unreduced inputs");
    for (int i = 0; i < N; i++) begin
      loadData[i] = int'($urandom_range(4095));
      modelA[i]   = loadData[i] % Q;
    end
    loadRam();
    modelForward();
    pushModel();
    applyStimulus(1'b0, FWD_LAT, 1);

    $display("[TB] reset mid-compute, then a fresh run");
    for (int i = 0; i < N; i++) begin
      loadData[i] = int'($urandom_range(Q - 1));
      modelA[i]   = loadData[i];
    end
    loadRam();
    applyStimulus(1'b1, INV_LAT, 2);
    modelForward();
    pushModel();
    applyStimulus(1'b0, FWD_LAT, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
